// File: rtl/axi_sram_slave.sv
// AXI4 slave backed by a byte-writable DEPTH x DATA_W SRAM, with independent read/write engines.
// Define AXI_SRAM_WRAP_EN to accept WRAP bursts; without it WRAP is answered with SLVERR.
module axi_sram_slave #(
  parameter int DATA_W = 64,
  parameter int ID_W   = 4,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              awvalid,
  output logic              awready,
  input  logic [31:0]       awaddr,
  input  logic [ID_W-1:0]   awid,
  input  logic [7:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic              wvalid,
  output logic              wready,
  input  logic              wlast,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic              bvalid,
  input  logic              bready,
  output logic [1:0]        bresp,
  output logic [ID_W-1:0]   bid,
  input  logic              arvalid,
  output logic              arready,
  input  logic [31:0]       araddr,
  input  logic [ID_W-1:0]   arid,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  output logic              rvalid,
  input  logic              rready,
  output logic              rlast,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic [ID_W-1:0]   rid
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam logic [2:0] SIZE_MAX  = 3'(OFF_W);
  localparam logic [2:0] RD_LAT_C  = 3'(RD_LAT);

`ifdef AXI_SRAM_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_WAIT = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;

  // A burst that cannot be served still runs its full beat count, but touches nothing.
  function automatic logic burst_err(input logic [2:0] sz, input logic [1:0] bu, input logic [7:0] ln);
    logic wrap_len_ok;
    wrap_len_ok = (ln == 8'd1) || (ln == 8'd3) || (ln == 8'd7) || (ln == 8'd15);
    burst_err = (sz > SIZE_MAX) || (bu == 2'b11) ||
                ((bu == BURST_WRAP) && (!WRAP_EN || !wrap_len_ok));
  endfunction

  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] sz,
                                            input logic [1:0] bu, input logic [7:0] ln);
    logic [31:0] step;
    logic [31:0] mask;
    step = 32'd1 << sz;
    mask = (({24'd0, ln} + 32'd1) << sz) - 32'd1;
    next_addr = a + step;
    if (bu == BURST_FIXED)
      next_addr = a;
    else if ((bu == BURST_WRAP) && WRAP_EN)
      next_addr = (a & ~mask) | ((a + step) & mask);
  endfunction

  // Write engine state
  logic [1:0]      w_state_reg;
  logic [31:0]     wr_addr_reg;
  logic [ID_W-1:0] wr_id_reg;
  logic [7:0]      wr_len_reg;
  logic [2:0]      wr_size_reg;
  logic [1:0]      wr_burst_reg;
  logic            wr_err_reg;
  logic            wlast_bad_reg;
  logic [7:0]      w_beat_reg;
  logic [1:0]      bresp_reg;

  // Read engine state
  logic [1:0]      r_state_reg;
  logic [31:0]     rd_addr_reg;
  logic [ID_W-1:0] rd_id_reg;
  logic [7:0]      rd_len_reg;
  logic [2:0]      rd_size_reg;
  logic [1:0]      rd_burst_reg;
  logic            rd_err_reg;
  logic [7:0]      r_beat_reg;
  logic [2:0]      wait_cnt_reg;
  logic [1:0]      rresp_reg;
  logic            rlast_reg;

  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic             rd_load;
  logic [31:0]      rd_load_addr;
  logic [IDX_W-1:0] rd_idx;

  assign awready = (w_state_reg == W_IDLE);
  assign wready  = (w_state_reg == W_DATA);
  assign bvalid  = (w_state_reg == W_RESP);
  assign bresp   = bresp_reg;
  assign bid     = wr_id_reg;

  assign arready = (r_state_reg == R_IDLE);
  assign rvalid  = (r_state_reg == R_DATA);
  assign rlast   = rlast_reg;
  assign rresp   = rresp_reg;
  assign rid     = rd_id_reg;

  assign wr_en  = !rst && (w_state_reg == W_DATA) && wvalid && !wr_err_reg;
  assign wr_idx = wr_addr_reg[OFF_W +: IDX_W];
  assign rd_idx = rd_load_addr[OFF_W +: IDX_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_reg   <= W_IDLE;
      wr_addr_reg   <= '0;
      wr_id_reg     <= '0;
      wr_len_reg    <= '0;
      wr_size_reg   <= '0;
      wr_burst_reg  <= '0;
      wr_err_reg    <= 1'b0;
      wlast_bad_reg <= 1'b0;
      w_beat_reg    <= '0;
      bresp_reg     <= RESP_OKAY;
    end else begin
      case (w_state_reg)
        W_IDLE: begin
          if (awvalid) begin
            wr_addr_reg   <= awaddr;
            wr_id_reg     <= awid;
            wr_len_reg    <= awlen;
            wr_size_reg   <= awsize;
            wr_burst_reg  <= awburst;
            wr_err_reg    <= burst_err(awsize, awburst, awlen);
            wlast_bad_reg <= 1'b0;
            w_beat_reg    <= '0;
            w_state_reg   <= W_DATA;
          end
        end
        W_DATA: begin
          if (wvalid) begin
            wr_addr_reg <= next_addr(wr_addr_reg, wr_size_reg, wr_burst_reg, wr_len_reg);
            w_beat_reg  <= w_beat_reg + 8'd1;
            // The beat count, not wlast, decides where the burst ends.
            if (w_beat_reg == wr_len_reg) begin
              w_state_reg <= W_RESP;
              bresp_reg   <= (wr_err_reg || wlast_bad_reg || !wlast) ? RESP_SLVERR : RESP_OKAY;
            end else if (wlast) begin
              wlast_bad_reg <= 1'b1;
            end
          end
        end
        W_RESP: begin
          if (bready)
            w_state_reg <= W_IDLE;
        end
        default: w_state_reg <= W_IDLE;
      endcase
    end
  end

  // The array is read at the last wait cycle and on every non-final R handshake,
  // so the following beat is on the bus one cycle after each handshake.
  always_comb begin
    rd_load      = 1'b0;
    rd_load_addr = rd_addr_reg;
    if ((r_state_reg == R_WAIT) && (wait_cnt_reg == RD_LAT_C))
      rd_load = 1'b1;
    if ((r_state_reg == R_DATA) && rready && !rlast_reg) begin
      rd_load      = 1'b1;
      rd_load_addr = next_addr(rd_addr_reg, rd_size_reg, rd_burst_reg, rd_len_reg);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_reg  <= R_IDLE;
      rd_addr_reg  <= '0;
      rd_id_reg    <= '0;
      rd_len_reg   <= '0;
      rd_size_reg  <= '0;
      rd_burst_reg <= '0;
      rd_err_reg   <= 1'b0;
      r_beat_reg   <= '0;
      wait_cnt_reg <= '0;
      rresp_reg    <= RESP_OKAY;
      rlast_reg    <= 1'b0;
    end else begin
      case (r_state_reg)
        R_IDLE: begin
          if (arvalid) begin
            rd_addr_reg  <= araddr;
            rd_id_reg    <= arid;
            rd_len_reg   <= arlen;
            rd_size_reg  <= arsize;
            rd_burst_reg <= arburst;
            rd_err_reg   <= burst_err(arsize, arburst, arlen);
            rresp_reg    <= burst_err(arsize, arburst, arlen) ? RESP_SLVERR : RESP_OKAY;
            r_beat_reg   <= '0;
            wait_cnt_reg <= '0;
            r_state_reg  <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (wait_cnt_reg == RD_LAT_C) begin
            r_state_reg <= R_DATA;
            rlast_reg   <= (rd_len_reg == 8'd0);
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 3'd1;
          end
        end
        R_DATA: begin
          if (rready) begin
            if (rlast_reg) begin
              r_state_reg <= R_IDLE;
              rlast_reg   <= 1'b0;
            end else begin
              rd_addr_reg <= rd_load_addr;
              r_beat_reg  <= r_beat_reg + 8'd1;
              rlast_reg   <= ((r_beat_reg + 8'd1) == rd_len_reg);
            end
          end
        end
        default: r_state_reg <= R_IDLE;
      endcase
    end
  end

  // One byte-wide RAM per lane; contents survive reset.
  for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] q_reg;

    always_ff @(posedge clk) begin
      if (wr_en && wstrb[gi])
        mem[wr_idx] <= wdata[gi*8 +: 8];
    end

    always_ff @(posedge clk) begin
      if (rst)
        q_reg <= 8'd0;
      else if (rd_load)
        q_reg <= rd_err_reg ? 8'd0 : mem[rd_idx];
    end

    assign rdata[gi*8 +: 8] = q_reg;
  end

endmodule
